prog_ctr: RTL

Program counter and fetch-sequencing unit for the single-cycle core. It consumes the ALU's branch result (`bOFFSET`, `bSIGN`) and its control requests (`reset`, `halt`), and produces the instruction-memory address each cycle. It also runs the start/run/halt handshake with the testbench or top level and keeps a retired-instruction count.

---
 rtl/definitions.sv | 14 +
 rtl/pc_next.sv | 34 +++
 rtl/prog_ctr.sv | 112 +++++++++++
 3 files changed

// File: rtl/definitions.sv
// Shared types and defaults for the program counter / fetch sequencer.
package definitions;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } pc_state_e;

    localparam int kPC_W_DEF       = 10;
    localparam int kSTART_ADDR_DEF = 0;

endpackage

// File: rtl/pc_next.sv
// Next-PC adder/subtractor: sequential increment or signed branch, with out-of-range flag.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module pc_next
    import definitions::*;
#(
    parameter int PC_W = kPC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [8:0]      boffset,
    input  logic            bsign,
    input  logic            branch,
    output logic [PC_W-1:0] pc_nxt,
    output logic            oor
);

    logic [PC_W-1:0] off;
    logic [PC_W:0]   sum;
    logic [PC_W:0]   dif;

    // One extra bit catches the carry past the top address or the borrow below zero.
    always_comb begin
        off    = PC_W'(boffset);
        sum    = {1'b0, pc} + {1'b0, off};
        dif    = {1'b0, pc} - {1'b0, off};
        pc_nxt = pc + PC_W'(1);
        oor    = 1'b0;
        if (branch) begin
            pc_nxt = bsign ? dif[PC_W-1:0] : sum[PC_W-1:0];
            oor    = bsign ? dif[PC_W] : sum[PC_W];
        end
    end

endmodule

// File: rtl/prog_ctr.sv
// Program counter, start/run/halt sequencer and retired-instruction counter (PC_BOUNDS_EN adds a bounds-fault state).
// Latency: next PC registered, visible one cycle after the inputs that select it.
// Backpressure: none; START is a pulse honoured only from IDLE or HALTED.
module prog_ctr
    import definitions::*;
#(
    parameter int PC_W       = kPC_W_DEF,
    parameter int START_ADDR = kSTART_ADDR_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             BRANCH,
    input  logic [8:0]       bOFFSET,
    input  logic             bSIGN,
    input  logic             ALU_RESET,
    input  logic             ALU_HALT,
    output logic [PC_W-1:0]  PC,
    output logic             RUNNING,
    output logic             DONE,
    output logic [CNT_W-1:0] INSTR_CNT,
    output logic             ERR
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_HALTED = HALTED;
`ifdef PC_BOUNDS_EN
    localparam logic [1:0] ST_FAULT  = FAULT;
`endif

    localparam logic [PC_W-1:0] kStart = PC_W'(START_ADDR);

    logic [1:0]      state;
    logic [PC_W-1:0] pc_nxt;
    logic            oor;
    logic            cnt_sat;

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc      (PC),
        .boffset (bOFFSET),
        .bsign   (bSIGN),
        .branch  (BRANCH),
        .pc_nxt  (pc_nxt),
        .oor     (oor)
    );

    assign cnt_sat = &INSTR_CNT;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            PC        <= kStart;
            INSTR_CNT <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    PC <= kStart;
                    if (START) begin
                        state     <= ST_RUN;
                        INSTR_CNT <= '0;
                    end
                end
                ST_RUN: begin
                    if (!cnt_sat) begin
                        INSTR_CNT <= INSTR_CNT + CNT_W'(1);
                    end
                    // An RST op overrides any branch; with halt it is the last commit.
                    if (ALU_RESET) begin
                        PC <= kStart;
                        if (ALU_HALT) begin
                            state <= ST_HALTED;
                        end
                    end
`ifdef PC_BOUNDS_EN
                    else if (oor) begin
                        state <= ST_FAULT;
                    end
`endif
                    else begin
                        PC <= pc_nxt;
                    end
                end
                ST_HALTED: begin
                    if (START) begin
                        state     <= ST_RUN;
                        PC        <= kStart;
                        INSTR_CNT <= '0;
                    end
                end
                default: begin
                    // Bounds fault is sticky until RESET_N.
                end
            endcase
        end
    end

    assign RUNNING = (state == ST_RUN);
    assign DONE    = (state == ST_HALTED);

`ifdef PC_BOUNDS_EN
    assign ERR = (state == ST_FAULT);
`else
    logic unused_oor;
    assign unused_oor = oor;
    assign ERR        = 1'b0;
`endif

endmodule
